// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage hazard/forwarding bus between the pipeline (master) and hazard_fwd_ctrl (slave).
interface hazard_fwd_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_src1;
  logic [4:0]       id_src2;
  logic             id_use_src2;
  logic [4:0]       id_dest;
  logic             id_wb_en;
  logic             id_mem_read;
  logic             flush;
  logic             hazard_stall;
  logic [1:0]       fwd_sel_a;
  logic [1:0]       fwd_sel_b;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_use_src2, id_dest, id_wb_en, id_mem_read, flush,
    input  hazard_stall, fwd_sel_a, fwd_sel_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_use_src2, id_dest, id_wb_en, id_mem_read, flush,
    output hazard_stall, fwd_sel_a, fwd_sel_b, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Load-use/RAW hazard detection and EX operand-forward select generation for a 5-stage pipeline.
// Define HAZARD_FWD_FORWARDING_EN to enable forwarding; otherwise every EX/MEM dependence stalls.
module hazard_fwd_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  hazard_fwd_ctrl_if.slave bus
);
  typedef struct packed {
    logic       valid;
    logic       wb_en;
    logic [4:0] dest;
    logic       mem_read;
  } slot_t;

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_MEM = 2'b01,
    SEL_WB  = 2'b10
  } fwd_sel_e;

  slot_t            ex_q, mem_q, wb_q, id_slot;
  logic [CNT_W-1:0] cnt_q;
  logic             src1_ex, src2_ex, src1_mem, src2_mem;
  logic             raw_stall, stall, advance;
  logic             unused_bits;

  function automatic logic hit(input slot_t s, input logic [4:0] src);
    return s.valid && s.wb_en && (s.dest == src) && (src != 5'd0);
  endfunction

  function automatic fwd_sel_e pick(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return SEL_MEM;
    else if (mem_hit) return SEL_WB;
    else              return SEL_RF;
  endfunction

  always_comb begin
    src1_ex  = hit(ex_q, bus.id_src1);
    src2_ex  = bus.id_use_src2 && hit(ex_q, bus.id_src2);
    src1_mem = hit(mem_q, bus.id_src1);
    src2_mem = bus.id_use_src2 && hit(mem_q, bus.id_src2);
  end

`ifdef HAZARD_FWD_FORWARDING_EN
  assign raw_stall = (src1_ex || src2_ex) && ex_q.mem_read;
`else
  assign raw_stall = src1_ex || src2_ex || src1_mem || src2_mem;
`endif

  // flush dominates a concurrent stall: the squashed instruction must not freeze the front end
  assign stall   = !rst && bus.id_valid && !bus.flush && raw_stall;
  assign advance = bus.id_valid && !stall && !bus.flush;

  always_comb begin
    id_slot          = '0;
    id_slot.valid    = 1'b1;
    id_slot.wb_en    = bus.id_wb_en;
    id_slot.dest     = bus.id_dest;
    id_slot.mem_read = bus.id_mem_read;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= advance ? id_slot : '0;
      if (stall && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // WB occupant is tracked for completeness only: the register file writes before it is read
  assign unused_bits = ^{wb_q, mem_q.mem_read, ex_q.mem_read};

`ifdef HAZARD_FWD_FORWARDING_EN
  fwd_sel_e sel_a_q, sel_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
    end else if (advance) begin
      sel_a_q <= pick(src1_ex, src1_mem);
      sel_b_q <= pick(src2_ex, src2_mem);
    end else begin
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
    end
  end

  assign bus.fwd_sel_a = sel_a_q;
  assign bus.fwd_sel_b = sel_b_q;
`else
  assign bus.fwd_sel_a = SEL_RF;
  assign bus.fwd_sel_b = SEL_RF;
`endif

  assign bus.hazard_stall = stall;
  assign bus.stall_cnt    = cnt_q;
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl; expectations follow HAZARD_FWD_FORWARDING_EN as compiled.
module tb_hazard_fwd_ctrl;
  localparam int unsigned CNT_W = 4;
`ifdef HAZARD_FWD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   n;
  logic [CNT_W-1:0] cnt_exp;

  always #5 clk = ~clk;

  hazard_fwd_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_fwd_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic u2, input logic [4:0] d, input logic wb, input logic mr);
    bus.id_valid    = v;
    bus.id_src1     = s1;
    bus.id_src2     = s2;
    bus.id_use_src2 = u2;
    bus.id_dest     = d;
    bus.id_wb_en    = wb;
    bus.id_mem_read = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction, hold it through any stall (bounded), then clock it into EX.
  task automatic issue(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u2, input logic [4:0] d, input logic wb, input logic mr,
                       output int stalls);
    set_id(v, s1, s2, u2, d, wb, mr);
    #1;
    stalls = 0;
    while (bus.hazard_stall === 1'b1 && stalls < 8) begin
      tick();
      stalls++;
    end
    tick();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    bus.flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #2;
    chk("rst_stall", bus.hazard_stall, 1'b0);
    chk("rst_sel_a", bus.fwd_sel_a, 2'b00);
    chk("rst_sel_b", bus.fwd_sel_b, 2'b00);
    chk("rst_cnt", bus.stall_cnt, 4'd0);
    tick();
    tick();
    rst = 1'b0;

    // add r3 ; sub r4 <- r3
    issue(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, n);
    chk("add_r3_stall", n, 0);
    issue(1'b1, 5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, n);
    chk("sub_dep_stall", n, FWD ? 0 : 2);
    chk("sub_sel_a", bus.fwd_sel_a, FWD ? 2'b01 : 2'b00);
    chk("sub_sel_b", bus.fwd_sel_b, 2'b00);
    cnt_exp = FWD ? 4'd0 : 4'd2;
    chk("cnt_after_sub", bus.stall_cnt, cnt_exp);

    // add r3 ; nop ; or reading r3 through src2
    issue(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, n);
    issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, n);
    issue(1'b1, 5'd7, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, n);
    chk("or_src2_stall", n, FWD ? 0 : 1);
    chk("or_src2_sel_b", bus.fwd_sel_b, FWD ? 2'b10 : 2'b00);
    chk("or_src2_sel_a", bus.fwd_sel_a, 2'b00);
    cnt_exp = FWD ? 4'd0 : 4'd3;
    chk("cnt_after_or", bus.stall_cnt, cnt_exp);

    // same, but src2 is an immediate field
    issue(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, n);
    issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, n);
    issue(1'b1, 5'd0, 5'd3, 1'b0, 5'd8, 1'b0, 1'b0, n);
    chk("or_imm_stall", n, 0);
    chk("or_imm_sel_b", bus.fwd_sel_b, 2'b00);

    // lw r5 ; add <- r5
    issue(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, n);
    chk("lw_r5_stall", n, 0);
    issue(1'b1, 5'd5, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, n);
    chk("load_use_stall", n, FWD ? 1 : 2);
    chk("load_use_sel_a", bus.fwd_sel_a, FWD ? 2'b10 : 2'b00);
    cnt_exp = FWD ? 4'd1 : 4'd5;
    chk("cnt_after_load_use", bus.stall_cnt, cnt_exp);

    // writes to r0 never create a dependence
    issue(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, n);
    issue(1'b1, 5'd0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, n);
    chk("r0_stall", n, 0);
    chk("r0_sel_a", bus.fwd_sel_a, 2'b00);
    chk("r0_sel_b", bus.fwd_sel_b, 2'b00);

    // lw r5 ; dependent add squashed by flush
    issue(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, n);
    set_id(1'b1, 5'd5, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    bus.flush = 1'b1;
    #1;
    chk("flush_stall", bus.hazard_stall, 1'b0);
    tick();
    bus.flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("flush_cnt", bus.stall_cnt, cnt_exp);
    chk("flush_sel_a", bus.fwd_sel_a, 2'b00);
    // the squashed add (r6) must not be in EX
    issue(1'b1, 5'd6, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, n);
    chk("post_flush_stall", n, 0);
    chk("post_flush_sel_a", bus.fwd_sel_a, 2'b00);

    // dependent load chain to drive the counter into saturation
    issue(1'b1, 5'd0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, n);
    for (int i = 0; i < 20; i++) begin
      issue(1'b1, 5'(10 + i), 5'd0, 1'b0, 5'(11 + i), 1'b1, 1'b1, n);
      chk("chain_stall", n, FWD ? 1 : 2);
      chk("chain_sel_a", bus.fwd_sel_a, FWD ? 2'b10 : 2'b00);
    end
    chk("cnt_saturated", bus.stall_cnt, 4'hF);

    // reset asserted in the middle of a stall
    issue(1'b1, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, n);
    set_id(1'b1, 5'd7, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    #1;
    chk("pre_rst_stall", bus.hazard_stall, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_stall", bus.hazard_stall, 1'b0);
    chk("async_rst_cnt", bus.stall_cnt, 4'd0);
    chk("async_rst_sel_a", bus.fwd_sel_a, 2'b00);
    chk("async_rst_sel_b", bus.fwd_sel_b, 2'b00);
    tick();
    chk("held_rst_stall", bus.hazard_stall, 1'b0);
    chk("held_rst_cnt", bus.stall_cnt, 4'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_stall", bus.hazard_stall, 1'b0);
    tick();
    chk("post_rst_cnt", bus.stall_cnt, 4'd0);
    chk("post_rst_sel_a", bus.fwd_sel_a, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
